// File: rtl/pipe_reg_d_e_if.sv
// D/E pipeline-register bus: D-stage fields, hazard controls and the registered E-stage fields.
interface pipe_reg_d_e_if;
  logic        stall;
  logic        flush;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] rs_data_D;
  logic [31:0] rt_data_D;
  logic [31:0] ext_D;
  logic [31:0] instr_E;
  logic [31:0] pc_E;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic [31:0] ext_E;
  logic [4:0]  reg_addr_E;
  logic [1:0]  t_new_E;
  logic        valid_E;

  modport master (
    output stall, flush, instr_D, pc_D, rs_data_D, rt_data_D, ext_D,
    input  instr_E, pc_E, rs_data_E, rt_data_E, ext_E, reg_addr_E, t_new_E, valid_E
  );

  modport slave (
    input  stall, flush, instr_D, pc_D, rs_data_D, rt_data_D, ext_D,
    output instr_E, pc_E, rs_data_E, rt_data_E, ext_E, reg_addr_E, t_new_E, valid_E
  );
endinterface

// File: rtl/pipe_reg_d_e.sv
// D->E pipeline register of the five-stage MIPS core, with bubble insertion and hazard-field decode.
// Optional macro BUBBLE_KEEP_PC_EN: a bubble carries pc_D into E instead of RESET_PC.
module pipe_reg_d_e #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic             clk,
  input logic             reset,
  pipe_reg_d_e_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  // Returns {reg_addr, t_new}; anything that writes no GPR reports 0/0.
  function automatic logic [6:0] decode_hazard(
    input logic [5:0] op,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] funct
  );
    logic [6:0] r;
    r = 7'd0;
    case (op)
      OP_RTYPE: if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLL) r = {rd, 2'd1};
      OP_ORI,
      OP_LUI:   r = {rt, 2'd1};
      OP_LW:    r = {rt, 2'd2};
      OP_JAL:   r = {5'd31, 2'd0};
      default:  r = 7'd0;
    endcase
    return r;
  endfunction

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] rs_data_p1;
  logic [31:0] rt_data_p1;
  logic [31:0] ext_p1;
  logic [4:0]  reg_addr_p1;
  logic [1:0]  t_new_p1;
  logic        vld_p1;

  logic [6:0]  hazard_p0;
  logic [31:0] bubble_pc_p0;
  logic        bubble_p0;

  assign hazard_p0 = decode_hazard(bus.instr_D[31:26], bus.instr_D[20:16],
                                   bus.instr_D[15:11], bus.instr_D[5:0]);
  assign bubble_p0 = bus.flush | bus.stall;

`ifdef BUBBLE_KEEP_PC_EN
  assign bubble_pc_p0 = bus.pc_D;
`else
  assign bubble_pc_p0 = RESET_PC;
`endif

  // D -> E boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1    <= 32'd0;
      pc_p1       <= RESET_PC;
      rs_data_p1  <= 32'd0;
      rt_data_p1  <= 32'd0;
      ext_p1      <= 32'd0;
      reg_addr_p1 <= 5'd0;
      t_new_p1    <= 2'd0;
      vld_p1      <= 1'b0;
    end else if (bubble_p0) begin
      instr_p1    <= 32'd0;
      pc_p1       <= bubble_pc_p0;
      rs_data_p1  <= 32'd0;
      rt_data_p1  <= 32'd0;
      ext_p1      <= 32'd0;
      reg_addr_p1 <= 5'd0;
      t_new_p1    <= 2'd0;
      vld_p1      <= 1'b0;
    end else begin
      instr_p1    <= bus.instr_D;
      pc_p1       <= bus.pc_D;
      rs_data_p1  <= bus.rs_data_D;
      rt_data_p1  <= bus.rt_data_D;
      ext_p1      <= bus.ext_D;
      reg_addr_p1 <= hazard_p0[6:2];
      t_new_p1    <= hazard_p0[1:0];
      vld_p1      <= 1'b1;
    end
  end

  assign bus.instr_E    = instr_p1;
  assign bus.pc_E       = pc_p1;
  assign bus.rs_data_E  = rs_data_p1;
  assign bus.rt_data_E  = rt_data_p1;
  assign bus.ext_E      = ext_p1;
  assign bus.reg_addr_E = reg_addr_p1;
  assign bus.t_new_E    = t_new_p1;
  assign bus.valid_E    = vld_p1;

endmodule

// File: doc/pipe_reg_d_e.md
# pipe_reg_d_e

Pipeline register between the decode (D) and execute (E) stages of the five-stage MIPS core. It captures the decoded instruction, its PC, the forwarded register operands and the extended immediate on every clock. It inserts a nop bubble into E when the hazard unit stalls D, or when a flush is requested. It also registers the hazard-tracking fields for the instruction in E: destination register address and Tnew. The hazard unit and forwarding muxes consume these directly.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset and carried by bubbles.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `stall` input, 1 bit: from the hazard unit; D is frozen, E receives a bubble.
- `flush` input, 1 bit: unconditionally replace the incoming D instruction with a bubble.
- `instr_D` input, 32 bits: instruction word in D.
- `pc_D` input, 32 bits: PC of `instr_D`.
- `rs_data_D` input, 32 bits: rs operand after D-stage forwarding.
- `rt_data_D` input, 32 bits: rt operand after D-stage forwarding.
- `ext_D` input, 32 bits: extended immediate.
- `instr_E` output, 32 bits: instruction in E.
- `pc_E` output, 32 bits: PC of `instr_E`.
- `rs_data_E` output, 32 bits: registered rs operand.
- `rt_data_E` output, 32 bits: registered rt operand.
- `ext_E` output, 32 bits: registered immediate.
- `reg_addr_E` output, 5 bits: GPR written by `instr_E`; 0 if none.
- `t_new_E` output, 2 bits: cycles until the result of `instr_E` is available to forward.
- `valid_E` output, 1 bit: 1 = real instruction, 0 = bubble.

## Operation
- Each rising edge selects one action, in this priority order:
  - reset
  - bubble, when `flush | stall`
  - load
- Load:
  - All data outputs take their D inputs.
  - `valid_E` = 1.
  - `reg_addr_E` and `t_new_E` are decoded from `instr_D`.
- Bubble:
  - `instr_E` = 0 (sll $0,$0,0, a nop).
  - `rs_data_E`, `rt_data_E` and `ext_E` = 0.
  - `reg_addr_E` = 0, `t_new_E` = 0, `valid_E` = 0.
  - `pc_E`: see Configuration.
- Decode of `instr_D`. R-type means op = 000000; supported instructions are add, sub, jr, sll, ori, lw, sw, beq, lui, jal.
  - add, sub, sll: `reg_addr` = rd, `t_new` = 1.
  - ori, lui: `reg_addr` = rt, `t_new` = 1.
  - lw: `reg_addr` = rt, `t_new` = 2.
  - jal: `reg_addr` = 31, `t_new` = 0. The result is PC+8, available at D/E.
  - All others (sw, beq, jr, unknown ops): `reg_addr` = 0, `t_new` = 0.
- sll with rd = 0 (which includes the nop encoding 0x00000000) yields `reg_addr_E` = 0, so no hazard is reported.
- A loaded instruction whose `reg_addr` decodes to 0 still has `valid_E` = 1.
- Reset values of all outputs:
  - `pc_E` = `RESET_PC`.
  - Every other output = 0, including `valid_E`.

## Timing
- Latency is one cycle: D inputs sampled at edge n are visible on the E outputs after edge n.
- All outputs are driven from flops only, with no combinational path from input to output.
- `stall` held for k cycles gives k consecutive bubbles. On the first edge after `stall` falls, the held D instruction is loaded exactly once.
- `stall` and `flush` asserted together give a single bubble per cycle.
- `reset` asserted together with `stall` or `flush`: reset wins.
- Deasserting `reset` mid-operation: loading resumes on the next edge, with no extra bubble.
- Operand values are never re-captured after load. Late forwarding for the instruction in E is the E-stage muxes' job.

## Configuration
- Macro: `BUBBLE_KEEP_PC_EN`.
- Defined: a bubble sets `pc_E` = `pc_D`. The PC of the stalled or flushed instruction stays visible in E for later exception and debug use.
- Undefined: a bubble sets `pc_E` = `RESET_PC`.
- All other behaviour is identical in both builds.

## Test plan
- Reset:
  - Stimulus: `reset`=1 for 2 cycles with arbitrary inputs.
  - Required: `pc_E`=0x00003000; `instr_E`, data outputs, `reg_addr_E`, `t_new_E`, `valid_E` all 0.
- Load lw:
  - Stimulus: `instr_D`=0x8C880004 (lw $8,4($4)), `pc_D`=0x3004, `rs_data_D`=0x10.
  - Required, next cycle: `instr_E`=0x8C880004, `pc_E`=0x3004, `rs_data_E`=0x10, `reg_addr_E`=8, `t_new_E`=2, `valid_E`=1.
- Stall run:
  - Stimulus: `stall`=1 for 3 cycles with add $3,$1,$2 held in D, then `stall`=0.
  - Required: three cycles of `instr_E`=0 and `valid_E`=0, then one cycle of the add with `reg_addr_E`=3 and `t_new_E`=1.
- jal and sw decode:
  - jal 0x0C000C10 → `reg_addr_E`=31, `t_new_E`=0.
  - sw 0xAC080000 → `reg_addr_E`=0, `t_new_E`=0, `valid_E`=1.
- Priority:
  - Stimulus: `flush`=1 and `stall`=1 in the same cycle.
  - Required: one bubble.
  - Stimulus: `reset`=1 and `flush`=1 in the same cycle.
  - Required: reset values.
- Macro:
  - Stimulus: bubble while `pc_D`=0x3010.
  - Required: `pc_E`=0x3010 with `BUBBLE_KEEP_PC_EN` defined, 0x3000 without it.
